// File: rtl/ga_pkg.sv
// Shared types and helpers for the logic-cell array configuration path.
package ga_pkg;

  localparam int CELL_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } cfg_state_t;

  function automatic int slots_f(input int dimx, input int port_width);
    return (dimx * CELL_BITS) / port_width;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Registered index-to-one-hot decoder; the output is all zero when valid is low.
module onehot_decoder #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] index,
  input  logic          valid,
  output logic [N-1:0]  onehot
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      onehot <= '0;
    end else if (valid) begin
      onehot <= N'(1) << index;
    end else begin
      onehot <= '0;
    end
  end

endmodule

// File: rtl/array_config_loader.sv
// Streams genome words from the config RAM onto the cell data bus and strobes
// one (row, slot) write enable per word.
module array_config_loader
  import ga_pkg::*;
#(
  parameter int DIMX       = 64,
  parameter int DIMY       = 64,
  parameter int PORT_WIDTH = 32,
  parameter int SLOTS      = slots_f(DIMX, PORT_WIDTH),
  parameter int NWORDS     = DIMY * SLOTS,
  parameter int AW         = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic                      rd_en,
  output logic [AW-1:0]             rd_addr,
  input  logic [PORT_WIDTH-1:0]     rd_data,
  output logic [DIMX*CELL_BITS-1:0] ram,
  output logic [NWORDS-1:0]         write_en,
  output logic                      busy,
  output logic                      done
);

  localparam logic [AW:0] LAST = (AW + 1)'(NWORDS - 1);

  cfg_state_t                state, state_nxt;
  logic [AW:0]               cnt, cnt_nxt;
  logic                      issue;
  logic                      wr_valid;
  logic [DIMX*CELL_BITS-1:0] ram_hold;
  logic [DIMX*CELL_BITS-1:0] ram_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter is one bit wider than the address so the terminal compare is exact.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + {{AW{1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        state_nxt = abort ? IDLE : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rd_en   = (state == FETCH);
  assign rd_addr = cnt[AW-1:0];
  assign busy    = (state == FETCH) || (state == DRAIN);
  assign done    = (state == DONE);

  // An abort cancels the read issued in the same cycle so it never reaches a row.
  assign issue    = rd_en && !abort;
  assign ram_word = {SLOTS{rd_data}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid <= 1'b0;
      ram_hold <= '0;
    end else begin
      wr_valid <= issue;
      if (wr_valid) begin
        ram_hold <= ram_word;
      end
    end
  end

  assign ram = wr_valid ? ram_word : ram_hold;

  onehot_decoder #(
    .N  (NWORDS),
    .IW (AW)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .index  (rd_addr),
    .valid  (issue),
    .onehot (write_en)
  );

endmodule

// File: tb/tb_array_config_loader.sv
// Directed self-checking bench for array_config_loader on a 2x16 array, 4 words.
module tb_array_config_loader;

  localparam int DIMX   = 16;
  localparam int DIMY   = 2;
  localparam int PW     = 32;
  localparam int NWORDS = 4;
  localparam int AW     = 2;
  localparam int RW     = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [PW-1:0]     rd_data;
  logic [RW-1:0]     ram;
  logic [NWORDS-1:0] write_en;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  bit sb_en = 1'b0;
  int sb_total = 0;
  int sb_bad_onehot = 0;
  int sb_bad_data = 0;
  int sb_hits [NWORDS];

  always #5 clk = ~clk;

  array_config_loader #(
    .DIMX       (DIMX),
    .DIMY       (DIMY),
    .PORT_WIDTH (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .ram      (ram),
    .write_en (write_en),
    .busy     (busy),
    .done     (done)
  );

  // One-cycle-latency config RAM holding word[k] = A0A0_0000 + k.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 32'hA0A0_0000 + 32'(rd_addr);
  end

  function automatic logic [RW-1:0] word(input int k);
    logic [PW-1:0] w;
    w = 32'hA0A0_0000 + 32'(k);
    return {w, w};
  endfunction

  // Strobe scoreboard for back-to-back loads.
  always @(negedge clk) begin
    if (sb_en && (write_en != '0)) begin
      sb_total++;
      if ($onehot(write_en)) begin
        for (int i = 0; i < NWORDS; i++) begin
          if (write_en[i]) begin
            sb_hits[i]++;
            if (ram !== word(i)) sb_bad_data++;
          end
        end
      end else begin
        sb_bad_onehot++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [AW-1:0] addr, input logic [RW-1:0] ram_exp);
    chk({tag, " rd_en"}, rd_en, 1'b0);
    chk({tag, " rd_addr"}, rd_addr, addr);
    chk({tag, " write_en"}, write_en, '0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " ram"}, ram, ram_exp);
  endtask

  // Pulses start in the current cycle and checks cycles 1..7 of a full load.
  task automatic run_load(input string tag, input bit repulse);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = repulse && (c == 2);
      chk($sformatf("%s c%0d rd_en", tag, c), rd_en, (c <= 4));
      chk($sformatf("%s c%0d rd_addr", tag, c), rd_addr, (c <= 4) ? c - 1 : 3);
      chk($sformatf("%s c%0d write_en", tag, c), write_en,
          (c >= 2 && c <= 5) ? (64'd1 << (c - 2)) : 64'd0);
      if (c >= 2 && c <= 5) chk($sformatf("%s c%0d ram", tag, c), ram, word(c - 2));
      else if (c >= 6) chk($sformatf("%s c%0d ram", tag, c), ram, word(3));
      chk($sformatf("%s c%0d busy", tag, c), busy, (c <= 5));
      chk($sformatf("%s c%0d done", tag, c), done, (c == 6));
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < NWORDS; i++) sb_hits[i] = 0;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset", '0, '0);
    reset = 1'b0;
    tick();
    check_idle("post_reset", '0, '0);

    // Reset asserted mid-cycle in the middle of a load.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midload busy before reset", busy, 1'b1);
    chk("midload write_en before reset", write_en, 4'b0010);
    #3;
    reset = 1'b1;
    #1;
    check_idle("midload_reset", '0, '0);
    tick();
    reset = 1'b0;
    tick();
    check_idle("after_midload_reset", '0, '0);

    // Plain full load.
    run_load("load", 1'b0);

    // Start re-pulsed during a load is ignored.
    run_load("repulse", 1'b1);

    // Abort while the third read is being issued.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort c1 rd_addr", rd_addr, 2'd0);
    chk("abort c1 write_en", write_en, 4'b0000);
    tick();
    chk("abort c2 write_en", write_en, 4'b0001);
    chk("abort c2 ram", ram, word(0));
    tick();
    chk("abort c3 write_en", write_en, 4'b0010);
    chk("abort c3 rd_addr", rd_addr, 2'd2);
    chk("abort c3 ram", ram, word(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort c4", 2'd2, word(1));
    tick();
    check_idle("abort c5", 2'd2, word(1));
    run_load("after_abort", 1'b0);

    // Start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort c1", 2'd3, word(3));
    tick();
    check_idle("start_abort c2", 2'd3, word(3));

    // Two back-to-back loads with a strobe scoreboard.
    sb_en = 1'b1;
    run_load("b2b_first", 1'b0);
    run_load("b2b_second", 1'b0);
    sb_en = 1'b0;
    chk("b2b strobe total", 64'(sb_total), 64'd8);
    chk("b2b not onehot", 64'(sb_bad_onehot), 64'd0);
    chk("b2b bad data", 64'(sb_bad_data), 64'd0);
    for (int i = 0; i < NWORDS; i++) begin
      chk($sformatf("b2b hits bit%0d", i), 64'(sb_hits[i]), 64'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
